// File: rtl/msdap_feeder_pkg.sv
// Shared constants, FSM state type and coefficient-entry layout for the
// MSDAP feeder slice.
package msdap_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned HIST_DEPTH = 256;
  localparam int unsigned COEFF_NUM  = 512;
  localparam int unsigned RJ_NUM     = 16;

  localparam int unsigned HIST_AW  = $clog2(HIST_DEPTH);
  localparam int unsigned FILL_W   = HIST_AW + 1;
  localparam int unsigned COEFF_AW = $clog2(COEFF_NUM);
  localparam int unsigned RJ_AW    = $clog2(RJ_NUM);
  localparam int unsigned RJ_W     = 8;
  localparam int unsigned SUM_W    = RJ_W + RJ_AW;

  // Coefficient entry: [8] sign (1 = negative), [7:0] delay index
  localparam int unsigned CE_W        = 9;
  localparam int unsigned CE_SIGN_BIT = 8;
  localparam int unsigned CE_IDX_MSB  = 7;
  localparam int unsigned CE_IDX_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FETCH = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/msdap_feeder_if.sv
// Feeder -> core data/coefficient-sign handshake bundle.
interface msdap_feeder_if;
  import msdap_pkg::*;

  logic [DATA_W-1:0] inData;
  logic              validData;
  logic              inCoeffSign;
  logic              readyForData;
  logic              readyForCoeffSign;

  modport master (
    output inData, validData, inCoeffSign,
    input  readyForData, readyForCoeffSign
  );

  modport slave (
    input  inData, validData, inCoeffSign,
    output readyForData, readyForCoeffSign
  );
endinterface

// File: rtl/msdap_feeder_hist_ram.sv
// Simple dual-address RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old data.
module msdap_feeder_hist_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage write and registered read
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/msdap_feeder.sv
// MSDAP feeder: keeps sample history, coefficient and rj tables, and on each
// new sample streams one frame of delayed samples with coefficient signs.
// Optional: MSDAP_FEEDER_SAMPLE_FIFO_EN adds a 4-entry sample FIFO ahead of IDLE.
module msdap_feeder
  import msdap_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   sampleIn,
  input  logic                sampleValid,
  output logic                sampleReady,
  input  logic                coeffWrEn,
  input  logic [COEFF_AW-1:0] coeffWrAddr,
  input  logic [CE_W-1:0]     coeffWrData,
  input  logic                rjWrEn,
  input  logic [RJ_AW-1:0]    rjWrAddr,
  input  logic [RJ_W-1:0]     rjWrData,
  msdap_feeder_if.master      core,
  output logic                busy,
  output logic                frameDone,
  output logic                cfgError
);

  state_e              state_q, state_d;
  logic                ph_q, ph_d;        // FETCH sub-phase: 0 coeff read, 1 history read
  logic [HIST_AW-1:0]  wp_q, wp_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [COEFF_AW-1:0] ptr_q, ptr_d;
  logic [RJ_AW-1:0]    j_q, j_d;
  logic [RJ_W-1:0]     cnt_q, cnt_d;
  logic                sign_q, sign_d;
  logic                zero_q, zero_d;
  logic                err_q, err_d;

  logic [RJ_W-1:0]     rj_q [RJ_NUM];
  logic [SUM_W-1:0]    rj_sum;
  logic [CE_W-1:0]     coeff_rdata;
  logic [HIST_AW-1:0]  coeff_idx;
  logic [HIST_AW-1:0]  hist_raddr;
  logic [DATA_W-1:0]   hist_rdata;
  logic [DATA_W-1:0]   cap_data;
  logic                start;
  logic                idle;

  assign idle = (state_q == IDLE);

`ifdef MSDAP_FEEDER_SAMPLE_FIFO_EN
  logic [2:0]        fwp_q, frp_q;
  logic              f_full, f_empty, f_push, f_pop;
  logic [DATA_W-1:0] f_rdata;

  assign f_empty = (fwp_q == frp_q);
  assign f_full  = (fwp_q[2] != frp_q[2]) && (fwp_q[1:0] == frp_q[1:0]);
  assign f_pop   = idle && !f_empty;
  // A pop frees the head slot this cycle, so a push onto a full FIFO is still taken.
  assign f_push  = sampleValid && (!f_full || f_pop);

  // FIFO pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwp_q <= '0;
      frp_q <= '0;
    end else begin
      if (f_push) fwp_q <= fwp_q + 3'd1;
      if (f_pop)  frp_q <= frp_q + 3'd1;
    end
  end

  msdap_feeder_hist_ram #(.DEPTH(4), .WIDTH(DATA_W)) u_fifo_ram (
    .clk_i   (clk),
    .we_i    (f_push),
    .waddr_i (fwp_q[1:0]),
    .wdata_i (sampleIn),
    .re_i    (f_pop),
    .raddr_i (frp_q[1:0]),
    .rdata_o (f_rdata)
  );

  assign start       = !f_empty;
  assign cap_data    = f_rdata;
  assign sampleReady = !f_full;
`else
  logic [DATA_W-1:0] sample_q;

  // Capture the accepted sample; it is written into history during LOAD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    sample_q <= '0;
    else if (idle && sampleValid)  sample_q <= sampleIn;
  end

  assign start       = sampleValid;
  assign cap_data    = sample_q;
  assign sampleReady = idle;
`endif

  // rj group-size table, writable only while idle
  always_ff @(posedge clk) begin
    if (rjWrEn && idle) rj_q[rjWrAddr] <= rjWrData;
  end

  // Total coefficients requested by the rj table
  always_comb begin
    rj_sum = '0;
    for (int unsigned i = 0; i < RJ_NUM; i++) rj_sum = rj_sum + SUM_W'(rj_q[i]);
  end

  msdap_feeder_hist_ram #(.DEPTH(COEFF_NUM), .WIDTH(CE_W)) u_coeff_ram (
    .clk_i   (clk),
    .we_i    (coeffWrEn && idle),
    .waddr_i (coeffWrAddr),
    .wdata_i (coeffWrData),
    .re_i    (state_q == FETCH && !ph_q),
    .raddr_i (ptr_q),
    .rdata_o (coeff_rdata)
  );

  assign coeff_idx  = coeff_rdata[CE_IDX_MSB:CE_IDX_LSB];
  // wp has already advanced past the newest sample when FETCH runs
  assign hist_raddr = wp_q - HIST_AW'(1) - coeff_idx;

  msdap_feeder_hist_ram #(.DEPTH(HIST_DEPTH), .WIDTH(DATA_W)) u_hist_ram (
    .clk_i   (clk),
    .we_i    (state_q == LOAD),
    .waddr_i (wp_q),
    .wdata_i (cap_data),
    .re_i    (state_q == FETCH && ph_q),
    .raddr_i (hist_raddr),
    .rdata_o (hist_rdata)
  );

  // State and frame-control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ph_q    <= 1'b0;
      wp_q    <= '0;
      fill_q  <= '0;
      ptr_q   <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      wp_q    <= wp_d;
      fill_q  <= fill_d;
      ptr_q   <= ptr_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  // Frame sequencing: next state and control updates
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    wp_d    = wp_q;
    fill_d  = fill_q;
    ptr_d   = ptr_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        wp_d   = wp_q + HIST_AW'(1);
        fill_d = (fill_q == FILL_W'(HIST_DEPTH)) ? fill_q : fill_q + FILL_W'(1);
        ptr_d  = '0;
        j_d    = '0;
        cnt_d  = '0;
        ph_d   = 1'b0;
        if (rj_sum > SUM_W'(COEFF_NUM)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (!ph_q) begin
          if (rj_q[j_q] == '0) begin
            if (j_q == RJ_AW'(RJ_NUM - 1)) state_d = DONE;
            else                          j_d     = j_q + RJ_AW'(1);
          end else begin
            ph_d = 1'b1;
          end
        end else begin
          sign_d  = coeff_rdata[CE_SIGN_BIT];
          zero_d  = ({1'b0, coeff_idx} >= fill_q);
          ph_d    = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (core.readyForData) begin
          ptr_d = ptr_q + COEFF_AW'(1);
          if (cnt_q + RJ_W'(1) == rj_q[j_q]) begin
            cnt_d = '0;
            if (j_q == RJ_AW'(RJ_NUM - 1)) begin
              state_d = DONE;
            end else begin
              j_d     = j_q + RJ_AW'(1);
              state_d = FETCH;
            end
          end else begin
            cnt_d   = cnt_q + RJ_W'(1);
            state_d = FETCH;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign core.validData   = (state_q == SEND);
  assign core.inCoeffSign = (state_q == SEND) && sign_q;
  assign core.inData      = ((state_q == SEND) && !zero_q) ? hist_rdata : '0;
  assign busy             = !idle;
  assign frameDone        = (state_q == DONE);
  assign cfgError         = err_q;

  // The core must be sampling the sign whenever it takes a data word
  a_sign_ready: assert property (@(posedge clk) disable iff (!reset)
    (core.validData && core.readyForData) |-> core.readyForCoeffSign);

endmodule

// File: tb/tb_msdap_feeder.sv
// Self-checking bench for msdap_feeder against a frame-level reference model.
module tb_msdap_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sampleIn;
  logic        sampleValid;
  logic        sampleReady;
  logic        coeffWrEn;
  logic [8:0]  coeffWrAddr;
  logic [8:0]  coeffWrData;
  logic        rjWrEn;
  logic [3:0]  rjWrAddr;
  logic [7:0]  rjWrData;
  logic        busy, frameDone, cfgError;

  msdap_feeder_if bus ();

  msdap_feeder dut (
    .clk         (clk),
    .reset       (reset),
    .sampleIn    (sampleIn),
    .sampleValid (sampleValid),
    .sampleReady (sampleReady),
    .coeffWrEn   (coeffWrEn),
    .coeffWrAddr (coeffWrAddr),
    .coeffWrData (coeffWrData),
    .rjWrEn      (rjWrEn),
    .rjWrAddr    (rjWrAddr),
    .rjWrData    (rjWrData),
    .core        (bus),
    .busy        (busy),
    .frameDone   (frameDone),
    .cfgError    (cfgError)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state
  logic [8:0]  coeff_m [512];
  logic [7:0]  rj_m [16];
  logic [15:0] samples [$];
  bit          err_m;
  logic [15:0] exp_d [$];
  bit          exp_s [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame contents from the rules: x[n-idx] per coefficient, zero before history
  task automatic build_expected();
    int unsigned sum = 0;
    int unsigned k = 0;
    int unsigned n;
    int unsigned idx;
    exp_d.delete();
    exp_s.delete();
    for (int j = 0; j < 16; j++) sum += rj_m[j];
    if (sum > 512) begin
      err_m = 1'b1;
      return;
    end
    n = samples.size();
    for (int j = 0; j < 16; j++) begin
      for (int c = 0; c < int'(rj_m[j]); c++) begin
        idx = coeff_m[k][7:0];
        exp_d.push_back(idx < n ? samples[n - 1 - idx] : 16'h0);
        exp_s.push_back(coeff_m[k][8]);
        k++;
      end
    end
  endtask

  task automatic wr_coeff(input int unsigned a, input logic [8:0] d);
    coeffWrEn = 1'b1; coeffWrAddr = 9'(a); coeffWrData = d;
    coeff_m[a] = d;
    @(negedge clk);
    coeffWrEn = 1'b0;
  endtask

  task automatic wr_rj(input int unsigned a, input logic [7:0] d);
    rjWrEn = 1'b1; rjWrAddr = 4'(a); rjWrData = d;
    rj_m[a] = d;
    @(negedge clk);
    rjWrEn = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    samples.delete();
    err_m = 1'b0;
    @(negedge clk);
  endtask

  // Push one sample and check the whole frame it produces. Called at a negedge.
  task automatic run_frame(input logic [15:0] x, input int unsigned stall_pct,
                           input bit long_stall, input bit busy_write, input bit sim_wr);
    int unsigned got = 0;
    int unsigned stall_left = 0;
    bit long_done = 0;
    bit done = 0;
    bit prev_stall = 0;
    bit rfd;
    logic [15:0] held_d;
    logic held_s;
    logic [8:0] nd;
    check("sampleReady_idle", sampleReady, 1);
    sampleValid = 1'b1;
    sampleIn = x;
    if (sim_wr) begin
      nd = 9'($urandom);
      coeffWrEn = 1'b1; coeffWrAddr = 9'd0; coeffWrData = nd;
      coeff_m[0] = nd;
    end
    samples.push_back(x);
    build_expected();
    @(negedge clk);
    sampleValid = 1'b0;
    coeffWrEn = 1'b0;
    for (int cyc = 0; cyc < 8000 && !done; cyc++) begin
      if (prev_stall) begin
        check("valid_held", bus.validData, 1);
        check("data_held", bus.inData, held_d);
        check("sign_held", bus.inCoeffSign, held_s);
      end
      if (long_stall && !long_done && got == 100) begin
        stall_left = 10;
        long_done = 1;
      end
      if (stall_left > 0) begin
        rfd = 0;
        stall_left--;
      end else begin
        rfd = ($urandom_range(99) >= stall_pct);
      end
      bus.readyForData = rfd;
      bus.readyForCoeffSign = rfd;
      if (busy_write && cyc == 6) begin
        coeffWrEn = 1'b1; coeffWrAddr = 9'd0; coeffWrData = ~coeff_m[0];
        rjWrEn = 1'b1; rjWrAddr = 4'd0; rjWrData = 8'd7;
      end else begin
        coeffWrEn = 1'b0;
        rjWrEn = 1'b0;
      end
      if (bus.validData && rfd) begin
        if (got < exp_d.size()) begin
          check("xfer_data", bus.inData, exp_d[got]);
          check("xfer_sign", bus.inCoeffSign, exp_s[got]);
        end else begin
          check("extra_xfer", got, exp_d.size());
        end
        got++;
      end
      prev_stall = bus.validData && !rfd;
      held_d = bus.inData;
      held_s = bus.inCoeffSign;
      if (frameDone) done = 1;
      @(negedge clk);
    end
    coeffWrEn = 1'b0;
    rjWrEn = 1'b0;
    check("frame_done_seen", done, 1);
    check("xfer_count", got, exp_d.size());
    check("cfgError", cfgError, err_m);
    check("frameDone_one_cycle", frameDone, 0);
    check("busy_after_frame", busy, 0);
  endtask

  initial begin
    reset = 1'b0;
    sampleIn = '0; sampleValid = 1'b0;
    coeffWrEn = 1'b0; coeffWrAddr = '0; coeffWrData = '0;
    rjWrEn = 1'b0; rjWrAddr = '0; rjWrData = '0;
    bus.readyForData = 1'b0; bus.readyForCoeffSign = 1'b0;
    err_m = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_validData", bus.validData, 0);
    check("rst_inData", bus.inData, 0);
    check("rst_inCoeffSign", bus.inCoeffSign, 0);
    check("rst_busy", busy, 0);
    check("rst_frameDone", frameDone, 0);
    check("rst_cfgError", cfgError, 0);
    check("rst_sampleReady", sampleReady, 1);
    reset = 1'b1;
    @(negedge clk);

    // rj all 1, coeff[0..15] = +x[n]
    for (int i = 0; i < 16; i++) wr_coeff(i, 9'h000);
    for (int i = 0; i < 16; i++) wr_rj(i, 8'd1);
    run_frame(16'h1234, 20, 0, 0, 0);

    // Random tables, random samples and backpressure
    for (int i = 0; i < 512; i++) wr_coeff(i, 9'($urandom));
    for (int i = 0; i < 16; i++) wr_rj(i, 8'($urandom_range(32)));
    for (int f = 0; f < 6; f++) run_frame(16'($urandom), 30, 0, 0, f == 3);

    // Pre-history zero fill and history wrap
    do_reset();
    wr_coeff(0, 9'h103);
    wr_rj(0, 8'd1);
    for (int i = 1; i < 16; i++) wr_rj(i, 8'd0);
    for (int f = 1; f <= 4; f++) run_frame(16'(f), 0, 0, 0, 0);
    for (int f = 0; f < 300; f++) run_frame(16'($urandom), 0, 0, 0, 0);

    // Full 512-coefficient frame, long stall, writes while busy dropped
    for (int i = 0; i < 512; i++) wr_coeff(i, 9'($urandom));
    wr_rj(0, 8'd255);
    wr_rj(1, 8'd255);
    wr_rj(2, 8'd2);
    run_frame(16'($urandom), 20, 1, 1, 0);
    run_frame(16'($urandom), 10, 0, 0, 0);

    // Oversubscribed rj table
    wr_rj(3, 8'd1);
    run_frame(16'($urandom), 0, 0, 0, 0);
    check("cfgError_sticky", cfgError, 1);

    // Reset in the middle of SEND
    wr_rj(3, 8'd0);
    bus.readyForData = 1'b0;
    bus.readyForCoeffSign = 1'b0;
    sampleIn = 16'hBEEF;
    sampleValid = 1'b1;
    @(negedge clk);
    sampleValid = 1'b0;
    for (int i = 0; i < 20 && !bus.validData; i++) @(negedge clk);
    check("midsend_valid_seen", bus.validData, 1);
    #2 reset = 1'b0;
    #1;
    check("midsend_validData_async", bus.validData, 0);
    check("midsend_busy_async", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    samples.delete();
    err_m = 1'b0;
    @(negedge clk);
    check("post_rst_sampleReady", sampleReady, 1);
    check("post_rst_cfgError", cfgError, 0);
    check("post_rst_validData", bus.validData, 0);
    run_frame(16'($urandom), 25, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
